boot_stream_writer: RTL and testbench



---
 rtl/boot_stream_pkg.sv | 12 +
 rtl/be_word_packer.sv | 49 ++++
 rtl/boot_stream_writer.sv | 144 ++++++++++++++
 tb/tb_boot_stream_writer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_stream_pkg.sv
// boot_stream_pkg: shared states, sizes and lane mapping for the boot stream writer
// No ports; imported by be_word_packer and boot_stream_writer.
package boot_stream_pkg;
   typedef enum logic [2:0] {S_LEN, S_ADDR, S_DATA, S_WR, S_ERR} state_t;
   localparam int ADDR_W_DEF = 36;
   localparam int WORD_BYTES = 8;
   localparam int HDR_BYTES  = 8;
   // Big-endian: lane 0 lands in bits [63:56], lane 7 in [7:0]; 8*(7-lane) == {~lane,3'b0}
   function automatic logic [5:0] lane_lsb(input logic [2:0] lane);
      return {~lane, 3'b000};
   endfunction
endpackage

// File: rtl/be_word_packer.sv
// be_word_packer: packs stream bytes into a 64-bit big-endian word with byte enables
// Ports: clk, rst_n (async, active-low); load stores din in the next lane; clr empties
//        the buffer; word/be are the current buffer and enables; full is high when the
//        current load fills the last lane.
module be_word_packer
   import boot_stream_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clr,
   input  logic [7:0]  din,
   output logic [63:0] word,
   output logic [7:0]  be,
   output logic        full
);
   logic [63:0] word_q, word_d;
   logic [7:0]  be_q, be_d;
   logic [3:0]  idx_q, idx_d;
   always_comb begin
      word_d = word_q;
      be_d   = be_q;
      idx_d  = idx_q;
      if (clr) begin
         word_d = '0;
         be_d   = '0;
         idx_d  = '0;
      end else if (load) begin
         word_d[lane_lsb(idx_q[2:0]) +: 8] = din;
         be_d[~idx_q[2:0]] = 1'b1;
         idx_d = idx_q + 4'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         be_q   <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         be_q   <= be_d;
         idx_q  <= idx_d;
      end
   end
   assign word = word_q;
   assign be   = be_q;
   // Lookahead so the FSM can raise the write request on the edge that fills the word
   assign full = idx_d == 4'(WORD_BYTES);
endmodule

// File: rtl/boot_stream_writer.sv
// boot_stream_writer: parses a length/address boot stream and writes its data bytes to memory
// Ports: clk, rst_n (async, active-low); rx_valid/rx_data/rx_ready byte input;
//        mem_req/mem_addr/mem_wdata/mem_be/mem_ack word write port; entry_addr is the load
//        address A; done pulses at transfer end; busy while a stream is in flight; err is a
//        sticky header error cleared only by reset.
module boot_stream_writer
   import boot_stream_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_be,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] entry_addr,
   output logic              done,
   output logic              busy,
   output logic              err
);
   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [63:0]         len_q, len_d;
   logic [55:0]         hdr_q, hdr_d;
   logic [ADDR_W-1:0]   rem_q, rem_d;
   logic [ADDR_W-4:0]   waddr_q, waddr_d;
   logic [ADDR_W-1:0]   entry_q, entry_d;
   logic                rx_ready_q, mem_req_q, done_q, done_d, err_q, err_d;
   logic                acc, hdr_err, pk_load, pk_clr, pk_full;
   logic [63:0]         a_new;
   logic [63:0]         pk_word;
   logic [7:0]          pk_be;

   be_word_packer u_packer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (pk_load),
      .clr  (pk_clr),
      .din  (rx_data),
      .word (pk_word),
      .be   (pk_be),
      .full (pk_full)
   );

   assign acc     = rx_valid && rx_ready_q;
   // Only the low 7 address bytes are kept; the top byte is shifted out on the 8th byte
   assign a_new   = {hdr_q, rx_data};
   assign hdr_err = (len_q[63:ADDR_W] != '0) || (a_new[63:ADDR_W] != '0) || (a_new[2:0] != 3'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      hdr_d   = hdr_q;
      rem_d   = rem_q;
      waddr_d = waddr_q;
      entry_d = entry_q;
      err_d   = err_q;
      done_d  = 1'b0;
      pk_load = 1'b0;
      pk_clr  = 1'b0;
      case (state_q)
         S_LEN: if (acc) begin
            len_d   = {len_q[55:0], rx_data};
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'(HDR_BYTES - 1)) ? S_ADDR : S_LEN;
         end
         S_ADDR: if (acc) begin
            hdr_d = a_new[55:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(HDR_BYTES - 1)) begin
               entry_d = a_new[ADDR_W-1:0];
               if (hdr_err) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else if (len_q == '0) begin
                  state_d = S_LEN;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DATA;
                  rem_d   = len_q[ADDR_W-1:0];
                  waddr_d = a_new[ADDR_W-1:3];
                  pk_clr  = 1'b1;
               end
            end
         end
         S_DATA: if (acc) begin
            pk_load = 1'b1;
            rem_d   = rem_q - ADDR_W'(1);
            state_d = (pk_full || rem_q == ADDR_W'(1)) ? S_WR : S_DATA;
         end
         S_WR: if (mem_ack) begin
            waddr_d = waddr_q + (ADDR_W-3)'(1);
            pk_clr  = 1'b1;
            done_d  = rem_q == '0;
            state_d = (rem_q == '0) ? S_LEN : S_DATA;
         end
         default: state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LEN;
         cnt_q      <= '0;
         len_q      <= '0;
         hdr_q      <= '0;
         rem_q      <= '0;
         waddr_q    <= '0;
         entry_q    <= '0;
         rx_ready_q <= 1'b0;
         mem_req_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         hdr_q      <= hdr_d;
         rem_q      <= rem_d;
         waddr_q    <= waddr_d;
         entry_q    <= entry_d;
         rx_ready_q <= state_d == S_LEN || state_d == S_ADDR || state_d == S_DATA;
         mem_req_q  <= state_d == S_WR;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = {waddr_q, 3'b000};
   assign mem_wdata  = pk_word;
   assign mem_be     = pk_be;
   assign entry_addr = entry_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = !(state_q == S_LEN && cnt_q == 3'd0);
endmodule

// File: tb/tb_boot_stream_writer.sv
// tb_boot_stream_writer: directed self-checking bench for boot_stream_writer
module tb_boot_stream_writer;
   logic        clk = 1'b0;
   logic        rst_n, rx_valid, rx_ready, mem_req, mem_ack, done, busy, err;
   logic [7:0]  rx_data, mem_be;
   logic [35:0] mem_addr, entry_addr;
   logic [63:0] mem_wdata;
   int          checks = 0, errors = 0, done_cnt = 0, req_cyc = 0, ack_delay = 0, wcnt = 0, r0;
   bit          unstable = 0, prev_req = 0;
   logic [107:0] prev_bus = '0;
   typedef struct {logic [35:0] a; logic [63:0] d; logic [7:0] b;} wr_t;
   wr_t         wq[$];

   always #5 clk = ~clk;

   boot_stream_writer #(.ADDR_W(36)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .entry_addr(entry_addr), .done(done), .busy(busy), .err(err)
   );

   // Memory responder: acknowledges after ack_delay cycles of a held request
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req) begin
            mem_ack = wcnt >= ack_delay;
            wcnt++;
         end else begin
            mem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Observer: records completed writes, done pulses, request cycles and bus stability
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (mem_req) req_cyc <= req_cyc + 1;
      if (mem_req && prev_req && {mem_addr, mem_wdata, mem_be} !== prev_bus) unstable <= 1'b1;
      prev_req <= mem_req;
      prev_bus <= {mem_addr, mem_wdata, mem_be};
      if (rst_n && mem_req && mem_ack) wq.push_back('{mem_addr, mem_wdata, mem_be});
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [63:0] n, input logic [63:0] a);
      for (int i = 0; i < 8; i++) send(n[63-8*i -: 8]);
      for (int i = 0; i < 8; i++) send(a[63-8*i -: 8]);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 100 && done_cnt < target; i++) @(negedge clk);
      chk("done_count", 64'(done_cnt), 64'(target));
   endtask

   task automatic chk_wr(input int i, input logic [35:0] a, input logic [63:0] d, input logic [7:0] b);
      if (wq.size() > i) begin
         chk($sformatf("wr%0d_addr", i), 64'(wq[i].a), 64'(a));
         chk($sformatf("wr%0d_data", i), wq[i].d, d);
         chk($sformatf("wr%0d_be", i), 64'(wq[i].b), 64'(b));
      end else chk($sformatf("wr%0d_present", i), 64'(wq.size()), 64'(i + 1));
   endtask

   initial begin
      rst_n = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rx_ready", 64'(rx_ready), 0);
      chk("rst_mem_req", 64'(mem_req), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", 64'(mem_be), 0);
      chk("rst_entry", 64'(entry_addr), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_err", 64'(err), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("rx_ready_after_rst", 64'(rx_ready), 1);

      // Two full words
      send_hdr(64'd16, 64'h8);
      chk("busy_in_data", 64'(busy), 1);
      for (int i = 0; i < 16; i++) begin
         send(8'(i));
         if (i == 7) begin
            chk("req_after_word", 64'(mem_req), 1);
            chk("ready_low_in_wr", 64'(rx_ready), 0);
            chk("req_addr", 64'(mem_addr), 64'h8);
         end
      end
      wait_done(1);
      chk("entry_full", 64'(entry_addr), 64'h8);
      chk_wr(0, 36'h8, 64'h0001020304050607, 8'hFF);
      chk_wr(1, 36'h10, 64'h08090A0B0C0D0E0F, 8'hFF);
      chk("busy_idle", 64'(busy), 0);

      // Partial word
      send_hdr(64'd3, 64'h100);
      send(8'hAA);
      send(8'hBB);
      send(8'hCC);
      wait_done(2);
      chk_wr(2, 36'h100, 64'hAABBCC0000000000, 8'hE0);

      // Empty transfer
      send_hdr(64'd0, 64'h40);
      chk("empty_done", 64'(done), 1);
      chk("empty_req", 64'(mem_req), 0);
      chk("empty_ready", 64'(rx_ready), 1);
      @(posedge clk);
      #1 chk("empty_done_drop", 64'(done), 0);
      wait_done(3);
      chk("empty_no_write", 64'(wq.size()), 3);
      chk("entry_empty", 64'(entry_addr), 64'h40);

      // Misaligned address
      r0 = req_cyc;
      send_hdr(64'd8, 64'h9);
      chk("mis_err", 64'(err), 1);
      chk("mis_ready", 64'(rx_ready), 0);
      rx_valid = 1'b1;
      repeat (10) @(negedge clk);
      rx_valid = 1'b0;
      chk("mis_ready_hold", 64'(rx_ready), 0);
      chk("mis_err_hold", 64'(err), 1);
      chk("mis_no_req", 64'(req_cyc), 64'(r0));
      rst_n = 1'b0;
      @(negedge clk);
      chk("err_cleared", 64'(err), 0);
      rst_n = 1'b1;
      send_hdr(64'd1, 64'h200);
      send(8'h5A);
      wait_done(4);
      chk_wr(3, 36'h200, 64'h5A00000000000000, 8'h80);

      // Address wrap
      send_hdr(64'd16, 64'hFFFFFFFF8);
      for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
      wait_done(5);
      chk("entry_wrap", 64'(entry_addr), 64'hFFFFFFFF8);
      chk_wr(4, 36'hFFFFFFFF8, 64'h1011121314151617, 8'hFF);
      chk_wr(5, 36'h0, 64'h18191A1B1C1D1E1F, 8'hFF);

      // Backpressure with a delayed ack and rx_valid held high
      ack_delay = 5;
      send_hdr(64'd9, 64'h300);
      for (int i = 0; i < 8; i++) send(8'(8'h40 + i));
      rx_valid = 1'b1;
      rx_data  = 8'h48;
      repeat (4) begin
         @(negedge clk);
         chk("bp_req_held", 64'(mem_req), 1);
         chk("bp_ready_low", 64'(rx_ready), 0);
      end
      send(8'h48);
      wait_done(6);
      chk("bp_stable", 64'(unstable), 0);
      chk_wr(6, 36'h300, 64'h4041424344454647, 8'hFF);
      chk_wr(7, 36'h308, 64'h4800000000000000, 8'h80);

      // Reset while a write is pending
      ack_delay = 50;
      send_hdr(64'd16, 64'h400);
      for (int i = 0; i < 8; i++) send(8'(8'h60 + i));
      chk("pre_rst_req", 64'(mem_req), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 64'(mem_req), 0);
      chk("mid_rst_ready", 64'(rx_ready), 0);
      chk("mid_rst_be", 64'(mem_be), 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      chk("mid_rst_addr", 64'(mem_addr), 0);
      chk("mid_rst_entry", 64'(entry_addr), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      ack_delay = 0;
      @(negedge clk);
      rst_n = 1'b1;
      send_hdr(64'd1, 64'h500);
      send(8'h77);
      wait_done(7);
      chk("post_rst_writes", 64'(wq.size()), 9);
      chk_wr(8, 36'h500, 64'h7700000000000000, 8'h80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
